multicycle_ctrl: RTL and testbench

//  Parametrised multicycle control FSM for the ARM-subset core. It sequences fetch, decode,

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/cond_check.sv | 34 +++
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, ARM condition
// codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExecR    = 4'd7,
    StExecI    = 4'd8,
    StAluWb    = 4'd9,
    StBranch   = 4'd10,
    StError    = 4'd11
  } state_t;

  localparam logic [3:0] CondEq = 4'h0;
  localparam logic [3:0] CondNe = 4'h1;
  localparam logic [3:0] CondCs = 4'h2;
  localparam logic [3:0] CondCc = 4'h3;
  localparam logic [3:0] CondMi = 4'h4;
  localparam logic [3:0] CondPl = 4'h5;
  localparam logic [3:0] CondVs = 4'h6;
  localparam logic [3:0] CondVc = 4'h7;
  localparam logic [3:0] CondHi = 4'h8;
  localparam logic [3:0] CondLs = 4'h9;
  localparam logic [3:0] CondGe = 4'hA;
  localparam logic [3:0] CondLt = 4'hB;
  localparam logic [3:0] CondGt = 4'hC;
  localparam logic [3:0] CondLe = 4'hD;
  localparam logic [3:0] CondAl = 4'hE;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResRdData = 2'b01;
  localparam logic [1:0] ResAluRes = 2'b10;

  localparam logic [1:0] OpDp     = 2'b00;
  localparam logic [1:0] OpMem    = 2'b01;
  localparam logic [1:0] OpBranch = 2'b10;

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against {N,Z,C,V}; AL and 1111 always pass.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b1;
    case (cond)
      CondEq:  pass = z;
      CondNe:  pass = !z;
      CondCs:  pass = c;
      CondCc:  pass = !c;
      CondMi:  pass = n;
      CondPl:  pass = !n;
      CondVs:  pass = v;
      CondVc:  pass = !v;
      CondHi:  pass = c && !z;
      CondLs:  pass = !c || z;
      CondGe:  pass = (n == v);
      CondLt:  pass = (n != v);
      CondGt:  pass = !z && (n == v);
      CondLe:  pass = z || (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing with a
// memory-ready handshake, wait-state watchdog and condition-code gating.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned TIMEOUT_CYC   = 15,
  parameter bit          COND_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_w,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_w,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       alu_op,
  output logic       flag_w_en,
  output logic       link,
  output logic       bus_error,
  output logic [3:0] state_o
);

  localparam int unsigned WdW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

  state_t         state_q, state_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic           ready, waiting, wd_expire, cond_pass, cmp_cmd;

  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  assign ready     = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign waiting   = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  // Fires on the edge that would complete the TIMEOUT_CYC-th wait cycle.
  assign wd_expire = (TIMEOUT_CYC != 0) && waiting && !ready && (wd_q == WdLast);
  assign cmp_cmd   = (funct[4:3] == 2'b10);
  assign state_o   = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     state_d = StFetch;
      StFetch:    state_d = ready ? StDecode : (wd_expire ? StError : StFetch);
      StDecode: begin
        if (COND_EN && !cond_pass) begin
          state_d = StFetch;
        end else begin
          case (op)
            OpMem:    state_d = StMemAddr;
            OpDp:     state_d = funct[5] ? StExecI : StExecR;
            OpBranch: state_d = StBranch;
            default:  state_d = StFetch;
          endcase
        end
      end
      StMemAddr:  state_d = funct[0] ? StMemRead : StMemWrite;
      StMemRead:  state_d = ready ? StMemWb : (wd_expire ? StError : StMemRead);
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = ready ? StFetch : (wd_expire ? StError : StMemWrite);
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StError:    state_d = StError;
      default:    state_d = StIdle;
    endcase
    wd_d = (waiting && !ready && (state_d == state_q)) ? wd_q + WdW'(1) : '0;
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_w      = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_w      = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBReg;
    result_src = ResAluOut;
    alu_op     = 1'b0;
    flag_w_en  = 1'b0;
    link       = 1'b0;
    bus_error  = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAluRes;
        ir_write   = ready;
        pc_write   = ready;
      end
      StDecode: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAluRes;
      end
      StMemAddr:  alu_src_b = SrcBImm;
      StMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      StMemWb: begin
        result_src = ResRdData;
        reg_w      = 1'b1;
        pc_write   = (rd == 4'd15);
      end
      StMemWrite: begin
        mem_req = 1'b1;
        mem_w   = 1'b1;
        adr_src = 1'b1;
      end
      StExecR, StExecI: begin
        alu_src_b = (state_q == StExecI) ? SrcBImm : SrcBReg;
        alu_op    = 1'b1;
        flag_w_en = funct[0];
      end
      StAluWb: begin
        reg_w    = !cmp_cmd;
        pc_write = !cmp_cmd && (rd == 4'd15);
      end
      StBranch: begin
        alu_src_b  = SrcBImm;
        result_src = ResAluRes;
        pc_write   = 1'b1;
        link       = funct[4];
        reg_w      = funct[4];
      end
      StError:  bus_error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table plus hand sequences
// for the watchdog and asynchronous reset.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cond, flags;
  logic       mem_ready;
  logic       mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, alu_src_a;
  logic [1:0] alu_src_b, result_src;
  logic       alu_op, flag_w_en, link, bus_error;
  logic [3:0] state_o;
  logic [14:0] outs;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .MEM_HANDSHAKE (1'b1),
    .TIMEOUT_CYC   (15),
    .COND_EN       (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .rd         (rd),
    .cond       (cond),
    .flags      (flags),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_w      (mem_w),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_w      (reg_w),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .flag_w_en  (flag_w_en),
    .link       (link),
    .bus_error  (bus_error),
    .state_o    (state_o)
  );

  assign outs = {mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, alu_src_a,
                 alu_src_b, result_src, alu_op, flag_w_en, link, bus_error};

  // {mem_req,mem_w,adr_src,ir_write,pc_write,reg_w,alu_src_a,alu_src_b,result_src,
  //  alu_op,flag_w_en,link,bus_error}
  localparam logic [14:0] O_IDLE = 15'b000_000_0_00_00_0000;
  localparam logic [14:0] O_FW   = 15'b100_000_1_10_10_0000;
  localparam logic [14:0] O_FR   = 15'b100_110_1_10_10_0000;
  localparam logic [14:0] O_DEC  = 15'b000_000_1_10_10_0000;
  localparam logic [14:0] O_MA   = 15'b000_000_0_01_00_0000;
  localparam logic [14:0] O_MR   = 15'b101_000_0_00_00_0000;
  localparam logic [14:0] O_MWB  = 15'b000_001_0_00_01_0000;
  localparam logic [14:0] O_MW   = 15'b111_000_0_00_00_0000;
  localparam logic [14:0] O_XR   = 15'b000_000_0_00_00_1000;
  localparam logic [14:0] O_XRS  = 15'b000_000_0_00_00_1100;
  localparam logic [14:0] O_XI   = 15'b000_000_0_01_00_1000;
  localparam logic [14:0] O_WB   = 15'b000_001_0_00_00_0000;
  localparam logic [14:0] O_WBPC = 15'b000_011_0_00_00_0000;
  localparam logic [14:0] O_BL   = 15'b000_011_0_01_10_0010;
  localparam logic [14:0] O_ERR  = 15'b000_000_0_00_00_0001;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  cond;
    logic [3:0]  flags;
    logic        ready;
    state_t      st;
    logic [14:0] out;
  } vec_t;

  vec_t vq[$];

  task automatic v(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                   input logic [3:0] c, input logic [3:0] fl, input logic rdy,
                   input state_t st, input logic [14:0] out);
    vq.push_back('{o, f, r, c, fl, rdy, st, out});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                       input logic [3:0] c, input logic [3:0] fl, input logic rdy);
    op = o; funct = f; rd = r; cond = c; flags = fl; mem_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(2'b00, 6'b001000, 4'd1, CondAl, 4'b0000, 1'b1);

    // ADD r1
    v(2'b00, 6'b001000, 4'd1, CondAl, 4'b0000, 1'b1, StIdle,   O_IDLE);
    v(2'b00, 6'b001000, 4'd1, CondAl, 4'b0000, 1'b1, StFetch,  O_FR);
    v(2'b00, 6'b001000, 4'd1, CondAl, 4'b0000, 1'b1, StDecode, O_DEC);
    v(2'b00, 6'b001000, 4'd1, CondAl, 4'b0000, 1'b1, StExecR,  O_XR);
    v(2'b00, 6'b001000, 4'd1, CondAl, 4'b0000, 1'b1, StAluWb,  O_WB);
    // CMP r0, S=1
    v(2'b00, 6'b010101, 4'd0, CondAl, 4'b0000, 1'b1, StFetch,  O_FR);
    v(2'b00, 6'b010101, 4'd0, CondAl, 4'b0000, 1'b1, StDecode, O_DEC);
    v(2'b00, 6'b010101, 4'd0, CondAl, 4'b0000, 1'b1, StExecR,  O_XRS);
    v(2'b00, 6'b010101, 4'd0, CondAl, 4'b0000, 1'b1, StAluWb,  O_IDLE);
    // ADDEQ with Z=0: skipped
    v(2'b00, 6'b001000, 4'd1, CondEq, 4'b0000, 1'b1, StFetch,  O_FR);
    v(2'b00, 6'b001000, 4'd1, CondEq, 4'b0000, 1'b1, StDecode, O_DEC);
    // BL
    v(2'b10, 6'b010000, 4'd0, CondAl, 4'b0000, 1'b1, StFetch,  O_FR);
    v(2'b10, 6'b010000, 4'd0, CondAl, 4'b0000, 1'b1, StDecode, O_DEC);
    v(2'b10, 6'b010000, 4'd0, CondAl, 4'b0000, 1'b1, StBranch, O_BL);
    // MOV pc, #imm
    v(2'b00, 6'b111010, 4'd15, CondAl, 4'b0000, 1'b1, StFetch,  O_FR);
    v(2'b00, 6'b111010, 4'd15, CondAl, 4'b0000, 1'b1, StDecode, O_DEC);
    v(2'b00, 6'b111010, 4'd15, CondAl, 4'b0000, 1'b1, StExecI,  O_XI);
    v(2'b00, 6'b111010, 4'd15, CondAl, 4'b0000, 1'b1, StAluWb,  O_WBPC);
    // LDR r2 with three read wait states
    v(2'b01, 6'b000001, 4'd2, CondAl, 4'b0000, 1'b1, StFetch,   O_FR);
    v(2'b01, 6'b000001, 4'd2, CondAl, 4'b0000, 1'b1, StDecode,  O_DEC);
    v(2'b01, 6'b000001, 4'd2, CondAl, 4'b0000, 1'b1, StMemAddr, O_MA);
    v(2'b01, 6'b000001, 4'd2, CondAl, 4'b0000, 1'b0, StMemRead, O_MR);
    v(2'b01, 6'b000001, 4'd2, CondAl, 4'b0000, 1'b0, StMemRead, O_MR);
    v(2'b01, 6'b000001, 4'd2, CondAl, 4'b0000, 1'b0, StMemRead, O_MR);
    v(2'b01, 6'b000001, 4'd2, CondAl, 4'b0000, 1'b1, StMemRead, O_MR);
    v(2'b01, 6'b000001, 4'd2, CondAl, 4'b0000, 1'b1, StMemWb,   O_MWB);
    // STR with one fetch wait and one write wait
    v(2'b01, 6'b000000, 4'd3, CondAl, 4'b0000, 1'b0, StFetch,    O_FW);
    v(2'b01, 6'b000000, 4'd3, CondAl, 4'b0000, 1'b1, StFetch,    O_FR);
    v(2'b01, 6'b000000, 4'd3, CondAl, 4'b0000, 1'b1, StDecode,   O_DEC);
    v(2'b01, 6'b000000, 4'd3, CondAl, 4'b0000, 1'b1, StMemAddr,  O_MA);
    v(2'b01, 6'b000000, 4'd3, CondAl, 4'b0000, 1'b0, StMemWrite, O_MW);
    v(2'b01, 6'b000000, 4'd3, CondAl, 4'b0000, 1'b1, StMemWrite, O_MW);
    // Illegal op under NE with Z=0: passes, then NOP back to fetch
    v(2'b11, 6'b000000, 4'd0, CondNe, 4'b0000, 1'b1, StFetch,  O_FR);
    v(2'b11, 6'b000000, 4'd0, CondNe, 4'b0000, 1'b1, StDecode, O_DEC);
    // ADDGT with N=V=1, Z=0: executes
    v(2'b00, 6'b001000, 4'd1, CondGt, 4'b1001, 1'b1, StFetch,  O_FR);
    v(2'b00, 6'b001000, 4'd1, CondGt, 4'b1001, 1'b1, StDecode, O_DEC);
    v(2'b00, 6'b001000, 4'd1, CondGt, 4'b1001, 1'b1, StExecR,  O_XR);
    v(2'b00, 6'b001000, 4'd1, CondGt, 4'b1001, 1'b1, StAluWb,  O_WB);
    // ADDLT with N=V=1: skipped
    v(2'b00, 6'b001000, 4'd1, CondLt, 4'b1001, 1'b1, StFetch,  O_FR);
    v(2'b00, 6'b001000, 4'd1, CondLt, 4'b1001, 1'b1, StDecode, O_DEC);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'(state_o), 32'(StIdle));
    chk("reset_outs", 32'(outs), 32'(O_IDLE));
    step();
    reset = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].op, vq[i].funct, vq[i].rd, vq[i].cond, vq[i].flags, vq[i].ready);
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(vq[i].st));
      chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vq[i].out));
      step();
    end
    chk("after_table_fetch", 32'(state_o), 32'(StFetch));

    // STR held 14 wait cycles, ready on the 15th: normal completion, no error
    drive(2'b01, 6'b000000, 4'd3, CondAl, 4'b0000, 1'b1);
    repeat (3) step();
    mem_ready = 1'b0;
    repeat (14) step();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("wd_edge_still_memwrite", 32'(state_o), 32'(StMemWrite));
    step();
    chk("wd_edge_ready_wins", 32'(state_o), 32'(StFetch));
    chk("wd_edge_no_error", 32'(bus_error), 32'd0);

    // Reset asserted mid-MEMWRITE drops the request immediately
    repeat (3) step();
    mem_ready = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("pre_reset_mem_w", 32'(mem_w), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_reset_mem_w", 32'(mem_w), 32'd0);
    chk("async_reset_mem_req", 32'(mem_req), 32'd0);
    chk("async_reset_state", 32'(state_o), 32'(StIdle));
    step();
    reset = 1'b1;
    step();

    // Fetch stalled forever: ERROR after 15 wait cycles, sticky
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("wd_fetch_wait%0d", i), 32'(state_o), 32'(StFetch));
      step();
    end
    @(negedge clk);
    chk("wd_error_state", 32'(state_o), 32'(StError));
    chk("wd_error_outs", 32'(outs), 32'(O_ERR));
    mem_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("error_sticky_state", 32'(state_o), 32'(StError));
    chk("error_sticky_bus_error", 32'(bus_error), 32'd1);
    reset = 1'b0;
    #1;
    chk("error_cleared_by_reset", 32'(bus_error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
